// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and bus widths for the Wishbone master arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} arb_state_t;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
endpackage

// File: rtl/wb_master_arbiter_if.sv
// wb_master_arbiter_if: bus masters plus decoder-side Wishbone bundle around the arbiter
interface wb_master_arbiter_if import wb_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] m_cyc_i;
  logic [NUM_MASTERS-1:0] m_stb_i;
  logic [NUM_MASTERS-1:0] m_we_i;
  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i;
  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i;
  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0] m_ack_o;
  logic [NUM_MASTERS-1:0] m_err_o;
  logic [WB_DAT_W-1:0] m_dat_o;
  logic s_cyc_o;
  logic s_stb_o;
  logic s_we_o;
  logic [WB_SEL_W-1:0] s_sel_o;
  logic [WB_ADR_W-1:0] s_adr_o;
  logic [WB_DAT_W-1:0] s_dat_o;
  logic s_ack_i;
  logic [WB_DAT_W-1:0] s_dat_i;
  logic [NUM_MASTERS-1:0] grant_o;
  logic timeout_o;
  modport slave (
    input m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output grant_o, timeout_o
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input grant_o, timeout_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] k;
  // Scan from farthest to nearest so the requester closest after ptr overwrites last.
  always_comb begin
    gnt = '0;
    idx = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = W'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin Wishbone master arbiter with per-transfer watchdog
module wb_master_arbiter import wb_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W = 8
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  wb_master_arbiter_if.slave bus
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  arb_state_t state;
  logic [NUM_MASTERS-1:0] req, nxt_gnt, grant;
  logic [IW-1:0] nxt_idx, g, ptr;
  logic [TIMEOUT_W-1:0] wd;
  logic busy, wait_c, timeout;
  logic [WB_SEL_W-1:0] sel_a [NUM_MASTERS];
  logic [WB_ADR_W-1:0] adr_a [NUM_MASTERS];
  logic [WB_DAT_W-1:0] dat_a [NUM_MASTERS];
  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign sel_a[k] = bus.m_sel_i[WB_SEL_W*k +: WB_SEL_W];
    assign adr_a[k] = bus.m_adr_i[WB_ADR_W*k +: WB_ADR_W];
    assign dat_a[k] = bus.m_dat_i[WB_DAT_W*k +: WB_DAT_W];
  end
  assign req = bus.m_cyc_i & bus.m_stb_i;
  rr_arbiter #(.N(NUM_MASTERS)) u_rr (.req(req), .ptr(ptr), .gnt(nxt_gnt), .idx(nxt_idx));
  // Slave side is live only in BUSY; IDLE and ERR present an idle bus.
  assign busy = state == BUSY;
  assign bus.s_cyc_o = busy & bus.m_cyc_i[g];
  assign bus.s_stb_o = busy & bus.m_stb_i[g];
  assign bus.s_we_o = busy & bus.m_we_i[g];
  assign bus.s_sel_o = busy ? sel_a[g] : '0;
  assign bus.s_adr_o = busy ? adr_a[g] : '0;
  assign bus.s_dat_o = busy ? dat_a[g] : '0;
  assign wait_c = bus.s_stb_o & ~bus.s_ack_i;
  assign bus.m_ack_o = (bus.s_stb_o & bus.s_ack_i) ? grant : '0;
  assign bus.m_err_o = state == ERR ? grant : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant;
  assign bus.timeout_o = timeout;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      g <= '0;
      ptr <= IW'(NUM_MASTERS - 1);
      wd <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= BUSY;
          grant <= nxt_gnt;
          g <= nxt_idx;
          ptr <= nxt_idx;
        end
        BUSY: if (!bus.m_cyc_i[g]) begin
          state <= IDLE;
          grant <= '0;
          wd <= '0;
        end else if (wait_c && wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          state <= ERR;
          wd <= '0;
          timeout <= 1'b1;
        end else
          wd <= wait_c ? wd + 1'b1 : '0;
        default: begin
          state <= bus.m_cyc_i[g] ? BUSY : IDLE;
          grant <= bus.m_cyc_i[g] ? grant : '0;
        end
      endcase
    end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: scoreboard bench for the two-master arbiter with an 8-cycle watchdog
module tb_wb_master_arbiter;
  typedef struct {
    logic [1:0] ack;
    logic [1:0] err;
    logic [31:0] adr;
    logic [31:0] rdat;
    logic [31:0] wdat;
    logic [3:0] sel;
    logic we;
    logic to;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] cyc_t = '0, stb_t = '0, we_t = '0;
  logic [31:0] adr_t [2];
  logic [31:0] dat_t [2];
  int lat = 1;
  logic force_ack = 1'b0;
  int wcnt = 0;
  int passed = 0, total = 0;
  exp_t q[$];
  wb_master_arbiter_if #(.NUM_MASTERS(2)) bus ();
  wb_master_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(8), .TIMEOUT_W(8)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.m_cyc_i = cyc_t;
  assign bus.m_stb_i = stb_t;
  assign bus.m_we_i = we_t;
  assign bus.m_sel_i = {4'h3, 4'hF};
  assign bus.m_adr_i = {adr_t[1], adr_t[0]};
  assign bus.m_dat_i = {dat_t[1], dat_t[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input bit k, input bit err, input logic [31:0] adr, rdat, wdat, input bit we, to);
    exp_t e;
    e.ack = err ? 2'b00 : (k ? 2'b10 : 2'b01);
    e.err = err ? (k ? 2'b10 : 2'b01) : 2'b00;
    e.adr = adr;
    e.rdat = rdat;
    e.wdat = wdat;
    e.sel = k ? 4'h3 : 4'hF;
    e.we = we;
    e.to = to;
    q.push_back(e);
  endtask

  // Decoder model: acks on the lat-th stb cycle (never when lat==0).
  always @(posedge clk) begin
    #2;
    if (bus.s_ack_i || rst || !bus.s_stb_o) wcnt = 0;
    if (!rst && bus.s_stb_o) wcnt++;
    bus.s_ack_i = force_ack || (!rst && lat != 0 && wcnt == lat);
    bus.s_dat_i = (bus.s_adr_o == 32'h3100_0004) ? 32'hDEAD_BEEF : ~bus.s_adr_o;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (|bus.m_ack_o || |bus.m_err_o)) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: ack %b err %b with nothing expected", bus.m_ack_o, bus.m_err_o);
      end else begin
        e = q.pop_front();
        chk("m_ack", 32'(bus.m_ack_o), 32'(e.ack));
        chk("m_err", 32'(bus.m_err_o), 32'(e.err));
        chk("grant", 32'(bus.grant_o), 32'(e.ack | e.err));
        chk("timeout", 32'(bus.timeout_o), 32'(e.to));
        if (|e.ack) begin
          chk("m_dat", bus.m_dat_o, e.rdat);
          chk("s_adr", bus.s_adr_o, e.adr);
          chk("s_dat", bus.s_dat_o, e.wdat);
          chk("s_sel", 32'(bus.s_sel_o), 32'(e.sel));
          chk("s_we", 32'(bus.s_we_o), 32'(e.we));
        end else begin
          chk("stb_in_err", 32'(bus.s_stb_o), 32'd0);
          chk("cyc_in_err", 32'(bus.s_cyc_o), 32'd0);
        end
      end
    end
  end

  task automatic run_master(input bit k, input logic [31:0] adr, input int beats, input bit we, input logic [31:0] wdat);
    int n;
    adr_t[k] = adr;
    dat_t[k] = wdat;
    we_t[k] = we;
    cyc_t[k] = 1'b1;
    stb_t[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus.m_ack_o[k] || bus.m_err_o[k]) && n < 100);
      if (n >= 100) begin
        total++;
        $display("FAIL wait_m%0d: no ack/err after %0d cycles, required within 100", k, n);
      end
      @(posedge clk);
      #1;
      adr_t[k] = adr + 32'(4 * (b + 1));
    end
    cyc_t[k] = 1'b0;
    stb_t[k] = 1'b0;
    we_t[k] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    adr_t[0] = '0; adr_t[1] = '0; dat_t[0] = '0; dat_t[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
    chk("rst_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.s_stb_o), 32'd0);
    chk("rst_ack", 32'(bus.m_ack_o), 32'd0);
    chk("rst_err", 32'(bus.m_err_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Single read, decoder acks two cycles after the request.
    lat = 2;
    push(0, 0, 32'h3100_0004, 32'hDEAD_BEEF, 32'h0, 0, 0);
    fork
      run_master(0, 32'h3100_0004, 1, 0, 32'h0);
      begin
        @(negedge clk);
        chk("arb_lat_c0_stb", 32'(bus.s_stb_o), 32'd0);
        @(negedge clk);
        chk("arb_lat_c1_stb", 32'(bus.s_stb_o), 32'd1);
        chk("arb_lat_c1_grant", 32'(bus.grant_o), 32'd1);
      end
    join
    chk("grant_released", 32'(bus.grant_o), 32'd0);
    // Spurious ack while idle must not reach any master.
    force_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("spurious_ack", 32'(bus.m_ack_o), 32'd0);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Simultaneous requesters alternate ownership.
    do_reset();
    lat = 1;
    push(0, 0, 32'h3000_0000, 32'hCFFF_FFFF, 32'h0, 0, 0);
    push(1, 0, 32'h3000_0100, 32'hCFFF_FEFF, 32'hB0B0_0000, 1, 0);
    push(0, 0, 32'h3000_0004, 32'hCFFF_FFFB, 32'h0, 0, 0);
    push(1, 0, 32'h3000_0104, 32'hCFFF_FEFB, 32'hB0B0_0001, 1, 0);
    push(0, 0, 32'h3000_0008, 32'hCFFF_FFF7, 32'h0, 0, 0);
    push(1, 0, 32'h3000_0108, 32'hCFFF_FEF7, 32'hB0B0_0002, 1, 0);
    fork
      for (int i = 0; i < 3; i++) run_master(0, 32'h3000_0000 + 32'(4 * i), 1, 0, 32'h0);
      for (int j = 0; j < 3; j++) run_master(1, 32'h3000_0100 + 32'(4 * j), 1, 1, 32'hB0B0_0000 + 32'(j));
    join
    // m1 burst keeps the grant while m0 waits.
    do_reset();
    lat = 2;
    push(1, 0, 32'h3000_0200, 32'hCFFF_FDFF, 32'h0, 0, 0);
    push(1, 0, 32'h3000_0204, 32'hCFFF_FDFB, 32'h0, 0, 0);
    push(1, 0, 32'h3000_0208, 32'hCFFF_FDF7, 32'h0, 0, 0);
    push(1, 0, 32'h3000_020C, 32'hCFFF_FDF3, 32'h0, 0, 0);
    push(0, 0, 32'h3000_0010, 32'hCFFF_FFEF, 32'h0, 0, 0);
    fork
      run_master(1, 32'h3000_0200, 4, 0, 32'h0);
      begin
        @(posedge clk);
        #1;
        run_master(0, 32'h3000_0010, 1, 0, 32'h0);
      end
    join
    // Ack on the 8th wait cycle beats the watchdog.
    do_reset();
    lat = 8;
    push(0, 0, 32'h3000_0020, 32'hCFFF_FFDF, 32'h0, 0, 0);
    run_master(0, 32'h3000_0020, 1, 0, 32'h0);
    chk("boundary_no_timeout", 32'(bus.timeout_o), 32'd0);
    // Silent slave: one error cycle, sticky timeout survives a later good transfer.
    lat = 0;
    push(0, 1, 32'h0, 32'h0, 32'h0, 0, 1);
    run_master(0, 32'h3000_0030, 1, 0, 32'h0);
    lat = 3;
    push(1, 0, 32'h3000_0040, 32'hCFFF_FFBF, 32'h0, 0, 1);
    run_master(1, 32'h3000_0040, 1, 0, 32'h0);
    chk("timeout_sticky", 32'(bus.timeout_o), 32'd1);
    // Asynchronous reset mid-transfer, then master 0 priority on restart.
    do_reset();
    lat = 3;
    adr_t[0] = 32'h3000_0050;
    cyc_t[0] = 1'b1;
    stb_t[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_stb", 32'(bus.s_stb_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_stb", 32'(bus.s_stb_o), 32'd0);
    chk("async_rst_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("async_rst_adr", bus.s_adr_o, 32'h0);
    chk("async_rst_grant", 32'(bus.grant_o), 32'd0);
    chk("async_rst_ack", 32'(bus.m_ack_o), 32'd0);
    cyc_t[0] = 1'b0;
    stb_t[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 1;
    push(0, 0, 32'h3000_0070, 32'hCFFF_FF8F, 32'h0, 0, 0);
    push(1, 0, 32'h3000_0060, 32'hCFFF_FF9F, 32'h0, 0, 0);
    fork
      run_master(0, 32'h3000_0070, 1, 0, 32'h0);
      run_master(1, 32'h3000_0060, 1, 0, 32'h0);
    join
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
